// File: rtl/dmem_responder_if.sv
// Load/store handshake bundle between the execute stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
   logic        dmem_read_req;
   logic [31:0] dmem_read_address;
   logic        dmem_write_req;
   logic [31:0] dmem_write_address;
   logic [3:0]  dmem_write_byte;
   logic [31:0] dmem_write_data;
   logic        dmem_write_ready;
   logic [31:0] dmem_read_data;
   logic        dmem_read_valid;
   logic        dmem_error;

   modport master (
      output dmem_read_req, dmem_read_address,
      output dmem_write_req, dmem_write_address, dmem_write_byte, dmem_write_data,
      input  dmem_write_ready, dmem_read_data, dmem_read_valid, dmem_error
   );

   modport slave (
      input  dmem_read_req, dmem_read_address,
      input  dmem_write_req, dmem_write_address, dmem_write_byte, dmem_write_data,
      output dmem_write_ready, dmem_read_data, dmem_read_valid, dmem_error
   );
endinterface

// File: rtl/dmem_responder.sv
// Data RAM with byte-masked stores and wait-stated word loads (IDLE/WAIT/RESP sequencer).
// Optional DMEM_RANGE_CHECK_EN: drop out-of-range stores, zero out-of-range loads, pulse dmem_error.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter int unsigned READ_LATENCY = 2
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] rd_idx;
   logic             rd_oor;
   logic [31:0]      read_data;
   logic             read_valid;
   logic             write_ready;
   logic             error;

   logic [31:0] mem [DEPTH_WORDS];

   logic [IDX_W-1:0] rd_idx_c;
   logic [IDX_W-1:0] wr_idx_c;
   logic             rd_in_range_c;
   logic             wr_in_range_c;
   logic             load_acc_c;
   logic             store_acc_c;
   logic             store_commit_c;
   logic             err_c;
   logic [31:0]      load_word_c;
   logic [31:0]      wait_word_c;
   logic             unused_addr_bits;

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  lanes);
      logic [31:0] res;
      for (int i = 0; i < 4; i++)
         res[8*i +: 8] = lanes[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      return res;
   endfunction

   assign rd_idx_c = bus.dmem_read_address[IDX_W+1:2];
   assign wr_idx_c = bus.dmem_write_address[IDX_W+1:2];

`ifdef DMEM_RANGE_CHECK_EN
   assign rd_in_range_c = (bus.dmem_read_address[31:IDX_W+2] == '0);
   assign wr_in_range_c = (bus.dmem_write_address[31:IDX_W+2] == '0);
`else
   assign rd_in_range_c = 1'b1;
   assign wr_in_range_c = 1'b1;
`endif

   // Byte offsets (and upper bits when wrapping) carry no meaning for a word RAM.
   assign unused_addr_bits = ^{bus.dmem_read_address, bus.dmem_write_address};

   assign load_acc_c     = (state == IDLE) && bus.dmem_read_req;
   assign store_acc_c    = bus.dmem_write_req && write_ready;
   assign store_commit_c = store_acc_c && wr_in_range_c && !reset;

`ifdef DMEM_RANGE_CHECK_EN
   assign err_c = (load_acc_c && !rd_in_range_c) || (store_acc_c && !wr_in_range_c);
`else
   assign err_c = 1'b0;
`endif

   // Word seen by a load accepted this cycle, merged with a same-cycle store to that word.
   always_comb begin
      load_word_c = mem[rd_idx_c];
      if (store_commit_c && (wr_idx_c == rd_idx_c))
         load_word_c = merge_lanes(mem[rd_idx_c], bus.dmem_write_data, bus.dmem_write_byte);
      if (!rd_in_range_c)
         load_word_c = '0;
   end

   assign wait_word_c = rd_oor ? 32'h0 : mem[rd_idx];

   // RAM array: not reset, written only while the sequencer is idle.
   always_ff @(posedge clk) begin
      if (store_commit_c) begin
         for (int i = 0; i < 4; i++)
            if (bus.dmem_write_byte[i])
               mem[wr_idx_c][8*i +: 8] <= bus.dmem_write_data[8*i +: 8];
      end
   end

   // Load sequencer with registered handshake outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         rd_idx      <= '0;
         rd_oor      <= 1'b0;
         read_data   <= '0;
         read_valid  <= 1'b0;
         write_ready <= 1'b1;
         error       <= 1'b0;
      end else begin
         read_valid <= 1'b0;
         error      <= err_c;
         case (state)
            IDLE: begin
               if (bus.dmem_read_req) begin
                  rd_idx      <= rd_idx_c;
                  rd_oor      <= !rd_in_range_c;
                  write_ready <= 1'b0;
                  if (READ_LATENCY == 1) begin
                     state      <= RESP;
                     cnt        <= '0;
                     read_data  <= load_word_c;
                     read_valid <= 1'b1;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state      <= RESP;
                  read_data  <= wait_word_c;
                  read_valid <= 1'b1;
               end
            end
            RESP: begin
               state       <= IDLE;
               cnt         <= '0;
               write_ready <= 1'b1;
            end
            default: begin
               state       <= IDLE;
               cnt         <= '0;
               write_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.dmem_read_data   = read_data;
   assign bus.dmem_read_valid  = read_valid;
   assign bus.dmem_write_ready = write_ready;
   assign bus.dmem_error       = error;
endmodule
